pc_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 16-bit CPU. It owns the program counter, fetches instructions over a simple req/ready instruction-memory handshake, and drives the ALU operand-A select: rs1 for branch/jump target computation, pc otherwise. It commits the next PC (sequential, jump, or taken branch) at the end of each instruction and supports execute-stage stalls and a sticky halt.

---
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller for the 16-bit CPU: owns the PC, fetches over a
// req/ready handshake, drives the ALU operand-A select and commits the next PC.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] instr_o,
    output logic        instr_valid_o,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        halt_i,
    input  logic        branch_taken_i,
    input  logic [15:0] alu_result_i,
    input  logic        stall_i,
    output logic        sel_rs1_o,
    output logic [15:0] pc_o,
    output logic        retire_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_e;

    state_e      state_q;
    logic [15:0] pc_q, instr_q, pc_d;
    logic        is_jump_q, is_branch_q, sel_rs1_q, req_q, ivalid_q, halted_q;

    always_comb begin
        pc_d = pc_q + 16'd1;
        if (is_jump_q || (is_branch_q && branch_taken_i))
            pc_d = alu_result_i;
    end

    // req_q is low out of reset so the request rises on the first edge after release;
    // a fetch can only complete while the request is up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= 16'h0000;
            is_jump_q   <= 1'b0;
            is_branch_q <= 1'b0;
            sel_rs1_q   <= 1'b0;
            req_q       <= 1'b0;
            ivalid_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ready_i) begin
                        instr_q  <= imem_rdata_i;
                        req_q    <= 1'b0;
                        ivalid_q <= 1'b1;
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ivalid_q <= 1'b0;
                    if (halt_i) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        is_jump_q   <= jump_i;
                        is_branch_q <= branch_i & ~jump_i;
                        sel_rs1_q   <= branch_i | jump_i;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall_i) begin
                        pc_q      <= pc_d;
                        sel_rs1_q <= 1'b0;
                        req_q     <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_HALT: begin
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // retire must mark the committing cycle itself, so it follows stall combinationally.
    assign retire_o      = (state_q == S_EXEC) && !stall_i;
    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = ivalid_q;
    assign sel_rs1_o     = sel_rs1_q;
    assign halted_o      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: an instruction-level model expands each
// instruction into per-cycle expectations that a negedge process compares.
module tb_pc_sequencer;

    localparam logic [15:0] RPC = 16'h0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ready, instr_valid, branch, jump, halt;
    logic        branch_taken, stall, sel_rs1, retire, halted;
    logic [15:0] imem_addr, imem_rdata, instr, alu_result, pc;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata),
        .instr_o(instr), .instr_valid_o(instr_valid),
        .branch_i(branch), .jump_i(jump), .halt_i(halt),
        .branch_taken_i(branch_taken), .alu_result_i(alu_result), .stall_i(stall),
        .sel_rs1_o(sel_rs1), .pc_o(pc), .retire_o(retire), .halted_o(halted)
    );

    typedef struct {
        logic        req, iv, sel, ret, hlt;
        logic [15:0] pc, instr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, failures = 0;
    logic [15:0] m_pc, m_instr;

    task automatic chk(string nm, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_req",    {15'd0, imem_req},    {15'd0, e.req});
            chk("imem_addr",   imem_addr,            e.pc);
            chk("pc",          pc,                   e.pc);
            chk("instr",       instr,                e.instr);
            chk("instr_valid", {15'd0, instr_valid}, {15'd0, e.iv});
            chk("sel_rs1",     {15'd0, sel_rs1},     {15'd0, e.sel});
            chk("retire",      {15'd0, retire},      {15'd0, e.ret});
            chk("halted",      {15'd0, halted},      {15'd0, e.hlt});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic req, logic iv, logic sel, logic ret, logic hlt);
        exp_t e;
        e.req = req; e.iv = iv; e.sel = sel; e.ret = ret; e.hlt = hlt;
        e.pc = m_pc; e.instr = m_instr;
        exp_q.push_back(e);
    endtask

    // Inputs a state does not listen to are kept random to show they are ignored.
    task automatic rand_in();
        imem_ready   = 1'($urandom_range(0, 1));
        imem_rdata   = 16'($urandom);
        branch       = 1'($urandom_range(0, 1));
        jump         = 1'($urandom_range(0, 1));
        halt         = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
        alu_result   = 16'($urandom);
        stall        = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(int n);
        rst_n   = 1'b0;
        m_pc    = RPC;
        m_instr = 16'h0000;
        for (int i = 0; i < n; i++) begin
            rand_in();
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        rst_n = 1'b1;
        rand_in();
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    // One instruction: w wait cycles in fetch, s stall cycles in execute.
    task automatic do_instr(int w, logic [15:0] rd, logic br, logic jp, logic ht,
                            logic tk, logic [15:0] tgt, int s);
        for (int i = 0; i <= w; i++) begin
            rand_in();
            imem_ready = (i == w);
            if (i == w) imem_rdata = rd;
            push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        m_instr = rd;
        rand_in();
        branch = br; jump = jp; halt = ht;
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        if (ht) return;
        for (int j = 0; j <= s; j++) begin
            rand_in();
            stall = (j < s);
            if (j == s) begin
                branch_taken = tk;
                alu_result   = tgt;
            end
            push(1'b0, 1'b0, br | jp, j == s, 1'b0);
            step();
        end
        m_pc = (jp || (br && tk)) ? tgt : m_pc + 16'd1;
    endtask

    task automatic halt_cycles(int n);
        for (int i = 0; i < n; i++) begin
            rand_in();
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
    endtask

    task automatic fetch_wait(int n);
        for (int i = 0; i < n; i++) begin
            rand_in();
            imem_ready = 1'b0;
            push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        rand_in();
        #1 rst_n = 1'b0;
        step();
        do_reset(2);

        do_instr(0, 16'h1111, 0, 0, 0, 0, 16'h0000, 0);
        do_instr(0, 16'h2222, 0, 0, 0, 0, 16'h0000, 0);
        do_instr(0, 16'h3333, 0, 0, 0, 0, 16'h0000, 0);
        chk("lit_seq_pc", pc, 16'h0013);
        chk("lit_seq_model", m_pc, 16'h0013);

        do_instr(4, 16'hA5A5, 0, 0, 0, 1, 16'hBEEF, 0);
        chk("lit_wait_instr", instr, 16'hA5A5);
        chk("lit_wait_pc", pc, 16'h0014);

        do_instr(0, 16'h4000, 0, 1, 0, 0, 16'h0200, 0);
        chk("lit_jump_pc", pc, 16'h0200);
        do_instr(1, 16'h5000, 1, 0, 0, 0, 16'h0300, 0);
        chk("lit_br_nt_pc", pc, 16'h0201);

        do_instr(0, 16'h6000, 1, 1, 0, 0, 16'h1234, 0);
        chk("lit_br_jmp_pc", pc, 16'h1234);
        do_instr(0, 16'h7000, 0, 1, 0, 0, 16'hFFFF, 0);
        do_instr(0, 16'h7001, 0, 0, 0, 0, 16'h5555, 0);
        chk("lit_wrap_pc", pc, 16'h0000);

        do_instr(0, 16'h8000, 0, 0, 0, 0, 16'h0000, 3);
        chk("lit_stall_pc", pc, 16'h0001);
        do_instr(2, 16'h8001, 1, 0, 0, 1, 16'h0ABC, 3);
        chk("lit_stall_br_pc", pc, 16'h0ABC);

        for (int k = 0; k < 60; k++)
            do_instr($urandom_range(0, 3), 16'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                     16'($urandom), $urandom_range(0, 3));

        do_instr(1, 16'hF00F, 1, 1, 1, 1, 16'h4444, 0);
        halt_cycles(20);

        do_reset(1);
        do_instr(0, 16'h9000, 0, 1, 0, 0, 16'h0500, 1);
        chk("lit_after_halt_pc", pc, 16'h0500);
        fetch_wait(2);
        do_reset(1);
        chk("lit_abort_pc", pc, RPC);
        do_instr(0, 16'h9001, 0, 0, 0, 0, 16'h0000, 0);
        chk("lit_abort_next_pc", pc, 16'h0011);

        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
